// File: rtl/pulse_arb_pkg.sv
// Shared types, defaults and round-robin helper for the pulse event arbiter.
// Optional feature macro used by the top level: PULSE_ARB_OVF_EN.
package pulse_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_CNT_W       = 3;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Next channel index after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// One-channel synchronizer chain plus history flop; emits a single-cycle strobe per
// rising edge of the asynchronous input.
module pulse_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic evt_strobe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_strobe = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/pulse_event_arbiter.sv
// Collects asynchronous pulse events into saturating per-channel counters and serves them
// round-robin over valid/ready. Define PULSE_ARB_OVF_EN for sticky overflow flags.
module pulse_event_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int unsigned ID_W       = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] async_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_ch,
`ifdef PULSE_ARB_OVF_EN
  output logic [NUM_CH-1:0] ovf_flag,
  input  logic [NUM_CH-1:0] ovf_clr,
`endif
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] dec_vec;
  logic [NUM_CH-1:0] nonzero;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic              handshake;
  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic [ID_W-1:0]   last_grant;
  arb_state_e        state_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .async_in  (async_pulse[i]),
      .evt_strobe(strobe[i])
    );

    assign dec_vec[i] = handshake && (evt_ch == ID_W'(i));
    assign nonzero[i] = (cnt_q[i] != '0);
  end

  assign handshake = evt_valid & evt_ready;
  assign busy      = (|nonzero) | evt_valid;

  // Simultaneous increment and decrement cancel; increments at saturation are dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (strobe[i] && !dec_vec[i]) begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (dec_vec[i] && !strobe[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // First non-empty channel searching upward from last_grant+1.
  always_comb begin
    int unsigned idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = rr_next(32'(last_grant), NUM_CH);
    for (int k = 0; k < NUM_CH; k++) begin
      if (!sel_found && nonzero[idx]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(idx);
      end
      idx = rr_next(idx, NUM_CH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      last_grant <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            evt_ch    <= sel_idx;
            evt_valid <= 1'b1;
            state_q   <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (evt_ready) begin
            evt_valid  <= 1'b0;
            last_grant <= evt_ch;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PULSE_ARB_OVF_EN
  logic [NUM_CH-1:0] drop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_drop
    assign drop[i] = strobe[i] & ~dec_vec[i] & (cnt_q[i] == CNT_MAX);
  end

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= '0;
    end else begin
      ovf_flag <= (ovf_flag & ~ovf_clr) | drop;
    end
  end
`endif

  a_hold_offer : assert property (@(posedge clk) disable iff (!rst_n)
    (evt_valid && !evt_ready) |=> (evt_valid && $stable(evt_ch)));

  a_offer_pending : assert property (@(posedge clk) disable iff (!rst_n)
    evt_valid |-> nonzero[evt_ch]);

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Scoreboard bench for pulse_event_arbiter: stimulus pushes expected grant channels, a
// forked monitor pops and compares on every handshake.
module tb_pulse_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] async_pulse = '0;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_ch;
  logic       busy;
`ifdef PULSE_ARB_OVF_EN
  logic [3:0] ovf_flag;
  logic [3:0] ovf_clr = '0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  pulse_event_arbiter #(
    .NUM_CH     (4),
    .CNT_W      (3),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_pulse(async_pulse),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
`ifdef PULSE_ARB_OVF_EN
    .ovf_flag   (ovf_flag),
    .ovf_clr    (ovf_clr),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] mask);
    async_pulse = async_pulse | mask;
    step(3);
    async_pulse = async_pulse & ~mask;
    step(3);
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 50 && !evt_valid; k++) step(1);
    check(name, 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && (busy || exp_q.size() != 0); k++) step(1);
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(evt_ch), 32'hdead);
        end else begin
          check("grant_ch", 32'(evt_ch), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    step(2);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ch", 32'(evt_ch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef PULSE_ARB_OVF_EN
    check("rst_ovf", 32'(ovf_flag), 32'd0);
`endif
    rst_n = 1'b1;
    step(2);

    // Single pulse on ch2: counter at E0+2, evt_valid at E0+3
    evt_ready = 1'b1;
    exp_q.push_back(2);
    async_pulse[2] = 1'b1;
    step(3);
    @(negedge clk);
    check("lat_valid_early", 32'(evt_valid), 32'd0);
    check("lat_busy_cnt", 32'(busy), 32'd1);
    step(1);
    @(negedge clk);
    check("lat_valid", 32'(evt_valid), 32'd1);
    check("lat_ch", 32'(evt_ch), 32'd2);
    step(1);
    @(negedge clk);
    check("lat_valid_drop", 32'(evt_valid), 32'd0);
    check("lat_busy_done", 32'(busy), 32'd0);
    step(1);
    async_pulse[2] = 1'b0;
    step(3);

    // Grant ch3 so the next search starts at ch0
    exp_q.push_back(3);
    pulse(4'b1000);
    wait_idle("pre_rr_idle");

    // Simultaneous pulses on all channels
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    pulse(4'b1111);
    wait_idle("rr_idle");

    // Stall: offer on ch1 must stay stable while ch2 becomes pending
    evt_ready = 1'b0;
    exp_q.push_back(1);
    exp_q.push_back(2);
    pulse(4'b0010);
    wait_valid("stall_valid");
    async_pulse[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) async_pulse[2] = 1'b0;
      @(negedge clk);
      check("stall_hold_valid", 32'(evt_valid), 32'd1);
      check("stall_hold_ch", 32'(evt_ch), 32'd1);
      step(1);
    end
    evt_ready = 1'b1;
    wait_idle("stall_idle");

    // Eight pulses on ch1 with consumer stalled: saturate at 7
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) pulse(4'b0010);
    step(4);
`ifdef PULSE_ARB_OVF_EN
    check("ovf_set", 32'(ovf_flag), 32'h2);
`endif
    for (int i = 0; i < 7; i++) exp_q.push_back(1);
    evt_ready = 1'b1;
    wait_idle("sat_idle");
    check("sat_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef PULSE_ARB_OVF_EN
    check("ovf_sticky", 32'(ovf_flag), 32'h2);
    ovf_clr = 4'b0010;
    step(1);
    ovf_clr = 4'b0000;
    check("ovf_clr", 32'(ovf_flag), 32'h0);
`endif

    // Increment on ch0 coincides with ch0's handshake
    evt_ready = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(0);
    async_pulse[0] = 1'b1;
    step(2);
    async_pulse[0] = 1'b0;
    step(4);
    wait_valid("coinc_valid");
    check("coinc_ch", 32'(evt_ch), 32'd0);
    step(2);
    async_pulse[0] = 1'b1;
    step(2);
    evt_ready = 1'b1;
    step(1);
    @(negedge clk);
    check("coinc_valid_drop", 32'(evt_valid), 32'd0);
    check("coinc_busy", 32'(busy), 32'd1);
    step(1);
    async_pulse[0] = 1'b0;
    wait_idle("coinc_idle");

    // Reset mid-offer with another event pending
    evt_ready = 1'b0;
    async_pulse = 4'b1010;
    step(2);
    async_pulse = 4'b0000;
    step(5);
    wait_valid("rst_mid_valid");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid_drop", 32'(evt_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    step(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step(20);
    check("post_rst_busy", 32'(busy), 32'd0);
    exp_q.push_back(2);
    pulse(4'b0100);
    wait_idle("post_rst_idle");

    step(4);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
